// File: rtl/apb2axi_drain_arbiter.sv
// apb2axi_drain_arbiter: round-robin sequencer for the response handler drain port.
// Optional counters (stat_*) are built when APB2AXI_DRAIN_STATS_EN is defined.
`timescale 1ns/1ps

package apb2axi_pkg;
    localparam int TAG_W      = 4;
    localparam int APB_DATA_W = 32;
endpackage

module apb2axi_drain_arbiter #(
    parameter int N_REQ     = 2,
    parameter int TAG_W     = apb2axi_pkg::TAG_W,
    parameter int APB_W     = apb2axi_pkg::APB_DATA_W,
    parameter int MAX_RETRY = 4
) (
    input  logic                   pclk,
    input  logic                   preset,
`ifdef APB2AXI_DRAIN_STATS_EN
    input  logic                   stat_clr,
    output logic [31:0]            stat_words,
    output logic [15:0]            stat_errs,
    output logic [15:0]            stat_retries,
`endif
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [APB_W-1:0]       rsp_data,
    output logic                   rsp_last,
    output logic                   rsp_err,
    output logic                   data_req,
    output logic [TAG_W-1:0]       data_req_tag,
    input  logic                   data_valid,
    input  logic [APB_W-1:0]       data_out,
    input  logic                   data_last
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] next_ptr;
    logic             found;
    logic [CNT_W-1:0] retry_cnt;
    logic [TAG_W-1:0] tag_q;
    logic             retry_hit;

    // This miss is the last one allowed for the current word.
    assign retry_hit = (int'(retry_cnt) + 1 == MAX_RETRY);
    assign next_ptr  = PTR_W'((int'(gnt) + 1) % N_REQ);
    assign data_req_tag = data_req ? tag_q : '0;

    // Pick the first requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and single-cycle strobes.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        data_req  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                data_req = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (data_valid || retry_hit) state_d = RESP;
                else                         state_d = ISSUE;
            end
            RESP: begin
                rsp_valid[gnt] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant latch, retry count, response capture and pointer advance.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rr_ptr    <= '0;
            gnt       <= '0;
            tag_q     <= '0;
            retry_cnt <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt       <= win;
                        tag_q     <= req_tag[int'(win)*TAG_W +: TAG_W];
                        retry_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (data_valid) begin
                        rsp_data <= data_out;
                        rsp_last <= data_last;
                        rsp_err  <= 1'b0;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        if (retry_hit) begin
                            rsp_data <= '0;
                            rsp_last <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                RESP:    rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

`ifdef APB2AXI_DRAIN_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            stat_words   <= '0;
            stat_errs    <= '0;
            stat_retries <= '0;
        end else if (stat_clr) begin
            stat_words   <= '0;
            stat_errs    <= '0;
            stat_retries <= '0;
        end else begin
            if (state_q == RESP && !rsp_err && stat_words != '1)
                stat_words <= stat_words + 1'b1;
            if (state_q == RESP && rsp_err && stat_errs != '1)
                stat_errs <= stat_errs + 1'b1;
            if (state_q == WAIT && !data_valid && stat_retries != '1)
                stat_retries <= stat_retries + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_apb2axi_drain_arbiter.sv
// tb_apb2axi_drain_arbiter: directed and random words against a
// transaction-level model of arbitration, retry and response timing.
`timescale 1ns/1ps

module tb_apb2axi_drain_arbiter;

    localparam int N  = 2;
    localparam int TW = apb2axi_pkg::TAG_W;
    localparam int DW = apb2axi_pkg::APB_DATA_W;
    localparam int MR = 4;

    typedef logic [N-1:0]    mask_t;
    typedef logic [N*TW-1:0] tags_t;

    logic          pclk = 1'b0;
    logic          preset;
    mask_t         req_valid;
    tags_t         req_tag;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic          data_req;
    logic [TW-1:0] data_req_tag;
    logic          data_valid;
    logic [DW-1:0] data_out;
    logic          data_last;
`ifdef APB2AXI_DRAIN_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_words;
    logic [15:0]   stat_errs;
    logic [15:0]   stat_retries;
`endif

    apb2axi_drain_arbiter #(
        .N_REQ(N), .TAG_W(TW), .APB_W(DW), .MAX_RETRY(MR)
    ) dut (
        .pclk(pclk),
        .preset(preset),
`ifdef APB2AXI_DRAIN_STATS_EN
        .stat_clr(stat_clr),
        .stat_words(stat_words),
        .stat_errs(stat_errs),
        .stat_retries(stat_retries),
`endif
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_last(rsp_last),
        .rsp_err(rsp_err),
        .data_req(data_req),
        .data_req_tag(data_req_tag),
        .data_valid(data_valid),
        .data_out(data_out),
        .data_last(data_last)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int            rr = 0;
    logic [DW-1:0] m_data = '0;
    logic          m_err = 1'b0;
    int            n_words = 0;
    int            n_errs = 0;
    int            n_retries = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input mask_t m);
        for (int k = 0; k < N; k++)
            if (m[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // One word: offer mask, handler misses 'misses' issues then answers.
    task automatic do_word(input mask_t mask, input tags_t tags,
                           input int misses, input logic [DW-1:0] word,
                           input logic lst);
        int g, n_exp, issues;
        bit exp_err, pend, pend_ok, done;
        @(negedge pclk);
        req_valid = mask;
        req_tag   = tags;
        #1;
        check("hold_data", rsp_data, m_data);
        check("hold_err", rsp_err, m_err);
        g = pick(mask);
        check("grant", req_ready, (g < 0) ? 0 : (1 << g));
        if (g < 0) return;
        exp_err = (misses >= MR);
        n_exp   = exp_err ? MR : misses + 1;
        issues  = 0;
        pend    = 0;
        pend_ok = 0;
        done    = 0;
        for (int c = 1; c <= 2 * MR + 4 && !done; c++) begin
            @(negedge pclk);
            req_valid = mask & ~(mask_t'(1) << g);
            if (pend) begin
                data_valid = pend_ok;
                data_out   = pend_ok ? word : $urandom;
                data_last  = pend_ok ? lst : 1'($urandom);
                pend       = 0;
            end else begin
                data_valid = 1'($urandom);
                data_out   = $urandom;
                data_last  = 1'($urandom);
            end
            #1;
            check("no_ready", req_ready, 0);
            if (data_req) begin
                issues++;
                check("req_tag", data_req_tag, tags[g*TW +: TW]);
                pend    = 1;
                pend_ok = (issues == misses + 1);
            end
            if (rsp_valid != 0) begin
                done = 1;
                check("rsp_who", rsp_valid, 1 << g);
                check("rsp_cycle", c, 1 + 2 * n_exp);
                check("issues", issues, n_exp);
                check("rsp_err", rsp_err, exp_err);
                check("rsp_data", rsp_data, exp_err ? '0 : word);
                check("rsp_last", rsp_last, exp_err ? 1'b0 : lst);
            end
        end
        if (!done) check("rsp_timeout", 0, 1);
        rr        = (g + 1) % N;
        m_data    = exp_err ? '0 : word;
        m_err     = exp_err;
        n_words   += exp_err ? 0 : 1;
        n_errs    += exp_err ? 1 : 0;
        n_retries += exp_err ? MR : misses;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        preset     = 1'b1;
        req_valid  = '0;
        req_tag    = '0;
        data_valid = 1'b0;
        data_out   = '0;
        data_last  = 1'b0;
`ifdef APB2AXI_DRAIN_STATS_EN
        stat_clr   = 1'b0;
`endif
        repeat (2) @(negedge pclk);
        check("rst_out",
              {req_ready, rsp_valid, data_req, data_req_tag,
               rsp_data, rsp_last, rsp_err}, 0);
        preset = 1'b0;

        // Single word answered on first issue.
        do_word(2'b01, {TW'(0), TW'(3)}, 0, 32'hCAFE0001, 1'b0);
        // Beat-load retry.
        do_word(2'b10, {TW'(5), TW'(0)}, 1, 32'h1234_5678, 1'b1);
        // Timeout.
        do_word(2'b01, {TW'(0), TW'(7)}, MR, 32'hDEAD_BEEF, 1'b1);
        // Bring the pointer to 0, then alternate under a held 2'b11.
        do_word(2'b10, {TW'(6), TW'(0)}, 0, 32'h0000_0042, 1'b0);
        for (int i = 0; i < 4; i++)
            do_word(2'b11, {TW'(2), TW'(1)}, 0, DW'($urandom), 1'b0);
        // Burst end drained in two words.
        do_word(2'b01, {TW'(0), TW'(4)}, 0, 32'hAAAA_0000, 1'b0);
        do_word(2'b01, {TW'(0), TW'(4)}, 0, 32'hBBBB_0001, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++)
            do_word(mask_t'($urandom), tags_t'($urandom),
                    int'($urandom_range(0, MR + 1)), DW'($urandom),
                    1'($urandom));

        // Reset while waiting for the handler.
        do_word(2'b10, {TW'(9), TW'(0)}, 0, 32'h0101_0101, 1'b0);
        @(negedge pclk);
        req_valid = 2'b10;
        req_tag   = {TW'(8), TW'(0)};
        #1;
        check("mid_grant", req_ready, 2'b10);
        @(negedge pclk);
        req_valid  = '0;
        data_valid = 1'b0;
        @(negedge pclk);
        data_valid = 1'b0;
        #2;
        preset = 1'b1;
        #1;
        check("mid_rst_out",
              {req_ready, rsp_valid, data_req, data_req_tag,
               rsp_data, rsp_last, rsp_err}, 0);
        @(negedge pclk);
        check("mid_rst_rsp", rsp_valid, 0);
        preset    = 1'b0;
        rr        = 0;
        m_data    = '0;
        m_err     = 1'b0;
        n_words   = 0;
        n_errs    = 0;
        n_retries = 0;
        do_word(2'b11, {TW'(2), TW'(1)}, 1, 32'h5555_AAAA, 1'b1);
        do_word(2'b11, {TW'(2), TW'(1)}, 0, 32'h7777_0000, 1'b0);

`ifdef APB2AXI_DRAIN_STATS_EN
        @(negedge pclk);
        check("stat_words", stat_words, n_words);
        check("stat_errs", stat_errs, n_errs);
        check("stat_retries", stat_retries, n_retries);
        do_word(2'b01, {TW'(0), TW'(1)}, MR, 32'h0, 1'b0);
        @(negedge pclk);
        check("stat_errs2", stat_errs, n_errs);
        stat_clr = 1'b1;
        @(negedge pclk);
        stat_clr = 1'b0;
        check("stat_clr", {stat_words, stat_errs, stat_retries}, 0);
`endif

        repeat (2) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb2axi_drain_arbiter.md
Name: apb2axi_drain_arbiter

Overview:
- Sequences the PCLK-side read-data drain port of the response handler (data_req / data_req_tag in, data_valid / data_out / data_last back).
- Arbitrates up to N_REQ word requesters (APB register read path, debug/trace port, ...) round-robin; one outstanding drain word at a time.
- Issues data_req pulses and retries when the handler has no beat loaded yet. Returns each word, or a timeout error, to the granted requester only.

Parameters:
- N_REQ, 2, number of requesters (>=1)
- TAG_W, TAG_W from apb2axi_pkg, tag width
- APB_W, APB_DATA_W from apb2axi_pkg (32), drained word width
- MAX_RETRY, 4, data_req issues per word before error (1..15)

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  requester i wants one word; held until req_ready[i]
- req_tag  in  N_REQ*TAG_W  tag of requester i, slice [i*TAG_W +: TAG_W]
- req_ready  out  N_REQ  one-hot grant/accept, single cycle
- rsp_valid  out  N_REQ  one-hot response strobe, single cycle
- rsp_data  out  APB_W  word for strobed requester (0 on error)
- rsp_last  out  1  word is end of burst (handler data_last)
- rsp_err  out  1  no data after MAX_RETRY issues
- data_req  out  1  drain request pulse to response handler
- data_req_tag  out  TAG_W  tag for data_req
- data_valid  in  1  handler word valid (1 cycle after sampled data_req)
- data_out  in  APB_W  handler word
- data_last  in  1  handler end-of-burst

Behaviour:
- Reset (async, preset=1): state IDLE, rr_ptr=0, retry_cnt=0. Outputs req_ready, rsp_valid, data_req, rsp_data, rsp_last, rsp_err and data_req_tag are all 0. A reset mid-operation abandons the word silently; no rsp_valid is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, winner g = first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - At the clock edge: latch tag=req_tag[g] and gnt=g, set retry_cnt=0, go to ISSUE.
  - No req_valid: remain in IDLE with all strobes low.
- ISSUE:
  - data_req=1 (decoded from state, exactly one cycle); data_req_tag=latched tag.
  - Go to WAIT.
- WAIT (handler answers in this cycle):
  - data_valid=1: capture data_out into rsp_data and data_last into rsp_last, set rsp_err=0, go to RESP.
  - data_valid=0: retry_cnt+1. If the new count equals MAX_RETRY, set rsp_data=0, rsp_last=0, rsp_err=1 and go to RESP. Otherwise go to ISSUE.
  - A data_valid=0 answer is normal on the first issue when the handler must first load a beat, so one retry is expected.
- RESP:
  - rsp_valid[gnt]=1 for one cycle, with rsp_data, rsp_last and rsp_err stable.
  - rr_ptr <= (gnt+1) mod N_REQ. Go to IDLE.
  - rsp_data, rsp_last and rsp_err hold their values until the next capture.
- Timing:
  - Minimum 4 cycles per word (IDLE→ISSUE→WAIT→RESP); each retry adds 2 cycles.
  - Worst case 2+2*MAX_RETRY cycles.
- Boundary conditions:
  - data_valid outside WAIT: ignored, no state change.
  - req_valid dropped before grant: legal, requester not selected.
  - req_valid of the granted requester still high in RESP: re-arbitrated in the next IDLE. rr_ptr already points past it, so other requesters win first.
  - N_REQ=1: rr_ptr is constant 0.
  - Duplicate tags from two requesters: served sequentially; words interleave per handler order. It is the software's responsibility to avoid this.
  - retry_cnt width is clog2(MAX_RETRY+1); it never wraps.

Optional Feature:
- APB2AXI_DRAIN_STATS_EN defined adds these outputs:
  - stat_words [31:0]: count of rsp_valid with rsp_err=0.
  - stat_errs [15:0]: count of rsp_valid with rsp_err=1.
  - stat_retries [15:0]: count of WAIT cycles with data_valid=0.
- Counter behaviour: all saturate at maximum and reset to 0 on preset; an input stat_clr (pulse) zeroes all three.
- Not defined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Single word, handler answers on 1st issue: req_valid[0]=1, tag=3, data_out=0xCAFE0001 in WAIT. Expect req_ready[0] in cycle 0, data_req in cycle 1 with tag 3, rsp_valid[0] in cycle 3, rsp_data=0xCAFE0001, rsp_err=0.
- Beat-load retry: handler returns data_valid=0 then 1. Expect exactly 2 data_req pulses and rsp_valid at cycle 5; stats build shows stat_retries=1.
- Timeout: data_valid held 0, MAX_RETRY=4. Expect 4 data_req pulses, then rsp_valid with rsp_err=1 and rsp_data=0; stat_errs=1.
- Round-robin fairness: req_valid=2'b11 held continuously, tags 1 and 2. Grants alternate 0,1,0,1 over 4 words; data_req_tag alternates 1,2,1,2.
- Burst end: 64b handler beat with RLAST drained in 2 words. rsp_last=0 on word 1, rsp_last=1 on word 2.
- Reset mid-op: assert preset while in WAIT. All outputs go to 0 asynchronously, no rsp_valid is issued, and the next request after release is granted to requester 0.
